datapath_core: RTL and testbench



---
 rtl/datapath_core.sv | 98 +++++++++
 tb/tb_datapath_core.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_core.sv
// datapath_core: 4x32 register file with two combinational read ports,
// one clocked write port and a 32-bit ALU whose result is written back.
//
// Ports:
//   clk        in   1  system clock, rising-edge state updates
//   rst        in   1  synchronous active-high reset
//   wr         in   1  write enable, result -> R[addr3] on rising edge
//   addr1      in   2  read address, port 1 (ALU operand A)
//   addr2      in   2  read address, port 2 (ALU operand B)
//   addr3      in   2  write address
//   alucontrol in   3  ALU operation select
//   data1      out 32  R[addr1], combinational
//   data2      out 32  R[addr2], combinational
//   result     out 32  ALU(data1, data2, alucontrol), combinational
//
// Build option: define DATAPATH_EXT_OPS_EN to enable slt/sll/srl
// (opcodes 101..111); without it those opcodes yield zero.

module datapath_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr,
    input  logic [1:0]  addr1,
    input  logic [1:0]  addr2,
    input  logic [1:0]  addr3,
    input  logic [2:0]  alucontrol,
    output logic [31:0] data1,
    output logic [31:0] data2,
    output logic [31:0] result
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
`ifdef DATAPATH_EXT_OPS_EN
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRL = 3'b111;
`endif

    // R3 seeds to one so software can derive +1/-1 from reset state.
    localparam logic [31:0] R0_RST = 32'h0000_0000;
    localparam logic [31:0] R1_RST = 32'h0000_0000;
    localparam logic [31:0] R2_RST = 32'h0000_0000;
    localparam logic [31:0] R3_RST = 32'h0000_0001;

    logic [31:0] regs_q [4];
    logic [31:0] regs_d [4];
    logic [31:0] alu_res;

    assign data1  = regs_q[addr1];
    assign data2  = regs_q[addr2];
    assign result = alu_res;

    always_comb begin
        alu_res = 32'h0;
        case (alucontrol)
            OP_ADD: alu_res = data1 + data2;
            OP_SUB: alu_res = data1 - data2;
            OP_AND: alu_res = data1 & data2;
            OP_OR:  alu_res = data1 | data2;
            OP_XOR: alu_res = data1 ^ data2;
`ifdef DATAPATH_EXT_OPS_EN
            OP_SLT: alu_res = {31'h0, $signed(data1) < $signed(data2)};
            OP_SLL: alu_res = data1 << data2[4:0];
            OP_SRL: alu_res = data1 >> data2[4:0];
`endif
            default: alu_res = 32'h0;
        endcase
    end

    // Operands come from the pre-edge register values, so a register
    // that is both source and destination updates exactly once.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr) begin
            regs_d[addr3] = alu_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q[0] <= R0_RST;
            regs_q[1] <= R1_RST;
            regs_q[2] <= R2_RST;
            regs_q[3] <= R3_RST;
        end else begin
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

endmodule

// File: tb/tb_datapath_core.sv
// tb_datapath_core: self-checking bench for datapath_core using a
// reference register model and a queue of expected ALU results.

module tb_datapath_core;

    logic        clk;
    logic        rst;
    logic        wr;
    logic [1:0]  addr1;
    logic [1:0]  addr2;
    logic [1:0]  addr3;
    logic [2:0]  alucontrol;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [31:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m [4];
    logic [31:0] exp_q [$];
    logic [31:0] exp;

    datapath_core dut (
        .clk        (clk),
        .rst        (rst),
        .wr         (wr),
        .addr1      (addr1),
        .addr2      (addr2),
        .addr3      (addr3),
        .alucontrol (alucontrol),
        .data1      (data1),
        .data2      (data2),
        .result     (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
`ifdef DATAPATH_EXT_OPS_EN
            3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6: return a << b[4:0];
            3'd7: return a >> b[4:0];
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive(input logic w, input logic [1:0] a1,
                         input logic [1:0] a2, input logic [1:0] a3,
                         input logic [2:0] op);
        @(negedge clk);
        wr = w;
        addr1 = a1;
        addr2 = a2;
        addr3 = a3;
        alucontrol = op;
    endtask

    // Advance one rising edge and update the model with pre-edge operands.
    task automatic tick();
        logic [31:0] nv;
        nv = alu_ref(alucontrol, m[addr1], m[addr2]);
        @(posedge clk);
        if (rst) begin
            m[0] = 32'h0;
            m[1] = 32'h0;
            m[2] = 32'h0;
            m[3] = 32'h1;
        end else if (wr) begin
            m[addr3] = nv;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 2'd0, 2'd0, 2'd0, 3'd0);
        tick();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            addr1 = 2'(i);
            addr2 = 2'(3 - i);
            #1;
            exp = (i == 3) ? 32'h1 : 32'h0;
            n_tests++;
            if (data1 !== exp) begin
                n_fail++;
                $display("FAIL reset_d1[%0d] got %h want %h", i, data1, exp);
            end
            exp = (i == 0) ? 32'h1 : 32'h0;
            n_tests++;
            if (data2 !== exp) begin
                n_fail++;
                $display("FAIL reset_d2[%0d] got %h want %h", i, data2, exp);
            end
        end
    endtask

    task automatic test_plan_seq();
        // R1 <= R0 - R0
        drive(1'b1, 2'd0, 2'd0, 2'd1, 3'd1);
        tick();
        addr1 = 2'd1;
        #1;
        n_tests++;
        if (data1 !== 32'h0) begin
            n_fail++;
            $display("FAIL r1_zero got %h want %h", data1, 32'h0);
        end
        // R0 <= R1 - R3, result visible before the edge
        drive(1'b1, 2'd1, 2'd3, 2'd0, 3'd1);
        exp_q.push_back(32'hFFFF_FFFF);
        #1;
        exp = exp_q.pop_front();
        n_tests++;
        if (result !== exp) begin
            n_fail++;
            $display("FAIL sub_neg got %h want %h", result, exp);
        end
        n_tests++;
        if (data1 !== 32'h0) begin
            n_fail++;
            $display("FAIL no_fwd got %h want %h", data1, 32'h0);
        end
        tick();
        drive(1'b1, 2'd1, 2'd0, 2'd2, 3'd0);
        n_tests++;
        if (data2 !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL r0_neg got %h want %h", data2, 32'hFFFF_FFFF);
        end
        tick();
        drive(1'b1, 2'd0, 2'd0, 2'd3, 3'd1);
        addr2 = 2'd2;
        #1;
        n_tests++;
        if (data2 !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL r2_add got %h want %h", data2, 32'hFFFF_FFFF);
        end
        addr2 = 2'd0;
        tick();
        addr1 = 2'd3;
        #1;
        n_tests++;
        if (data1 !== 32'h0) begin
            n_fail++;
            $display("FAIL r3_zero got %h want %h", data1, 32'h0);
        end
    endtask

    task automatic test_no_write();
        drive(1'b0, 2'd2, 2'd2, 2'd1, 3'd4);
        tick();
        for (int i = 0; i < 4; i++) begin
            addr1 = 2'(i);
            #1;
            n_tests++;
            if (data1 !== m[i]) begin
                n_fail++;
                $display("FAIL hold[%0d] got %h want %h", i, data1, m[i]);
            end
        end
    endtask

    task automatic test_rst_priority();
        drive(1'b1, 2'd0, 2'd0, 2'd3, 3'd3);
        rst = 1'b1;
        tick();
        @(negedge clk);
        rst = 1'b0;
        wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            addr2 = 2'(i);
            #1;
            exp = (i == 3) ? 32'h1 : 32'h0;
            n_tests++;
            if (data2 !== exp) begin
                n_fail++;
                $display("FAIL rst_prio[%0d] got %h want %h", i, data2, exp);
            end
        end
    endtask

    task automatic test_ext_ops();
        // fresh reset state, then R0 <= R1 - R3 = -1
        drive(1'b1, 2'd1, 2'd3, 2'd0, 3'd1);
        tick();
        drive(1'b0, 2'd0, 2'd3, 2'd0, 3'd5);
`ifdef DATAPATH_EXT_OPS_EN
        exp_q.push_back(32'd1);
`else
        exp_q.push_back(32'd0);
`endif
        #1;
        exp = exp_q.pop_front();
        n_tests++;
        if (result !== exp) begin
            n_fail++;
            $display("FAIL slt got %h want %h", result, exp);
        end
        addr1 = 2'd3;
        alucontrol = 3'd6;
`ifdef DATAPATH_EXT_OPS_EN
        exp_q.push_back(32'd2);
`else
        exp_q.push_back(32'd0);
`endif
        #1;
        exp = exp_q.pop_front();
        n_tests++;
        if (result !== exp) begin
            n_fail++;
            $display("FAIL sll got %h want %h", result, exp);
        end
        addr1 = 2'd0;
        alucontrol = 3'd7;
`ifdef DATAPATH_EXT_OPS_EN
        exp_q.push_back(32'h7FFF_FFFF);
`else
        exp_q.push_back(32'd0);
`endif
        #1;
        exp = exp_q.pop_front();
        n_tests++;
        if (result !== exp) begin
            n_fail++;
            $display("FAIL srl got %h want %h", result, exp);
        end
    endtask

    task automatic test_back_to_back();
        // R3 <= R3 + R3 held for 4 edges: 1 -> 2 -> 4 -> 8 -> 16
        drive(1'b1, 2'd3, 2'd3, 2'd3, 3'd0);
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(m[3] + m[3]);
            tick();
            exp = exp_q.pop_front();
            n_tests++;
            if (data1 !== exp) begin
                n_fail++;
                $display("FAIL b2b[%0d] got %h want %h", k, data1, exp);
            end
        end
        n_tests++;
        if (data1 !== 32'd16) begin
            n_fail++;
            $display("FAIL b2b_final got %h want %h", data1, 32'd16);
        end
    endtask

    task automatic test_random();
        logic [1:0] a3;
        for (int k = 0; k < 60; k++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  3'($urandom_range(0, 7)));
            rst = ($urandom_range(0, 19) == 0);
            exp_q.push_back(alu_ref(alucontrol, m[addr1], m[addr2]));
            #1;
            exp = exp_q.pop_front();
            n_tests++;
            if (result !== exp) begin
                n_fail++;
                $display("FAIL rnd_res[%0d] op %0d got %h want %h",
                         k, alucontrol, result, exp);
            end
            a3 = addr3;
            tick();
            @(negedge clk);
            rst = 1'b0;
            wr = 1'b0;
            addr1 = a3;
            #1;
            n_tests++;
            if (data1 !== m[a3]) begin
                n_fail++;
                $display("FAIL rnd_wb[%0d] got %h want %h", k, data1, m[a3]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        wr = 1'b0;
        addr1 = 2'd0;
        addr2 = 2'd0;
        addr3 = 2'd0;
        alucontrol = 3'd0;
        test_reset();
        test_plan_seq();
        test_no_write();
        test_rst_priority();
        test_ext_ops();
        test_rst_priority();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
